// File: rtl/pulse_hs_tx.sv
// Transmit side of a four-phase pulse-crossing handshake: queues local event
// pulses and launches each as a req level. Optional overflow flag: PULSE_HS_TX_OVF_EN.
module pulse_hs_tx #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             src_pulse_i,
  input  logic             ack_async_i,
  input  logic             ovf_clr_i,
  output logic             req_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] pend_cnt_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_s1_q, ack_s2_q;
  logic             launch;
  logic             ovf_set;

  // Two-flop synchroniser for the remote acknowledge
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
    end else begin
      ack_s1_q <= ack_async_i;
      ack_s2_q <= ack_s1_q;
    end
  end

  // Handshake state, request level and pending counter
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    launch  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cnt_q != '0) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          launch  = 1'b1;
        end
      end
      ST_REQ: begin
        req_d = 1'b1;
        if (ack_s2_q) begin
          state_d = ST_DROP;
          req_d   = 1'b0;
        end
      end
      ST_DROP: begin
        req_d = 1'b0;
        if (!ack_s2_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Saturating pending count; a pulse at full count without a launch is dropped
  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    if (src_pulse_i && !launch) begin
      if (&cnt_q) begin
        ovf_set = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!src_pulse_i && launch) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

`ifdef PULSE_HS_TX_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow; a new drop outranks a clear in the same cycle
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_clr_i ^ ovf_set;
  assign ovf_o      = 1'b0;
`endif

  assign req_o      = req_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign pend_cnt_o = cnt_q;

endmodule

// File: doc/pulse_hs_tx.md
# pulse_hs_tx

Transmit end of the single-bit pulse-crossing handshake. It takes one-cycle event pulses in the local clock domain, queues them in a pending counter, and launches each one as a four-phase request level toward a remote-domain receiver. That receiver synchronises `req_o` with two flops, edge-detects it into a single pulse, and returns its synchronised level as `ack_async_i`. The block sits in the source domain of any event that must cross to an unrelated clock, for example interrupt or wakeup events.

## Interface
- `CNT_W`, default 4: width of the pending-event counter. Range 1..8.
- `clk` input 1: local clock. All state updates on the rising edge.
- `rst_b` input 1: reset. Synchronous and active-low.
- `src_pulse_i` input 1: event strobe. Each high cycle is one event.
- `ack_async_i` input 1: receiver's synchronised copy of `req_o`. Asynchronous to `clk`.
- `req_o` output 1: request level to the remote domain. Driven directly from a flop.
- `busy_o` output 1: high while a handshake is in progress (state ≠ IDLE).
- `pend_cnt_o` output CNT_W: number of events not yet launched.
- `ovf_o` output 1: sticky flag; an event was dropped because the counter was full.
- `ovf_clr_i` input 1: clears `ovf_o`.

## Operation
- Ack path:
  - `ack_async_i` passes through a two-flop synchroniser, `ack_s1` then `ack_s2`.
  - Only `ack_s2` is used by the logic.
- FSM states: IDLE, REQ, DROP.
  - IDLE, `pend_cnt != 0`: go to REQ, set `req_o` = 1, decrement the counter (the launch).
  - REQ: hold `req_o` = 1 until `ack_s2` = 1, then go to DROP and set `req_o` = 0.
  - DROP: hold `req_o` = 0 until `ack_s2` = 0, then go to IDLE.
  - No launch is evaluated in the DROP→IDLE transition cycle.
- Counter update, per cycle:
  - `+1` when `src_pulse_i` is high.
  - `−1` on a launch.
  - Both in the same cycle: net unchanged.
- Counter full, i.e. all ones:
  - `src_pulse_i` with no launch that cycle: the event is dropped, the count stays at max, `ovf_o` is set.
  - `src_pulse_i` in the same cycle as a launch: count stays at max, no overflow.
- `ovf_o` is sticky.
  - `ovf_clr_i` clears it on the next edge.
  - Clear and set in the same cycle: set wins.
- `src_pulse_i` held high for N cycles counts as N events.
- Reset (`rst_b` = 0 at a rising edge), regardless of state:
  - state IDLE, `req_o` 0, `pend_cnt_o` 0, `ovf_o` 0, `ack_s1`/`ack_s2` 0.
  - Pending events are discarded.
  - Reset mid-handshake drops `req_o` on that edge. The receiver then sees the request fall without a further pulse.

## Timing
- Launch latency:
  - `src_pulse_i` at edge n, counter 0, state IDLE: `pend_cnt_o` = 1 after edge n.
  - Launch at edge n+1: `req_o` = 1 and `pend_cnt_o` = 0 after edge n+1.
- Ack latency: `ack_async_i` rising before edge m gives `ack_s2` = 1 after edge m+1.
  - In REQ, `req_o` falls after edge m+2.
  - The falling ack is handled symmetrically in DROP.
- Minimum local-side cycle, excluding remote latency: 1 cycle in IDLE plus REQ and DROP, each lasting at least 3 cycles of `ack` propagation.
- `busy_o` is combinational from the state register.
  - Goes high in the same cycle `req_o` rises.
  - Goes low when the state returns to IDLE.
- All outputs change only on `clk` rising edges. None is combinational from an input.

## Configuration
- Macro: `PULSE_HS_TX_OVF_EN`.
- Defined: the overflow flag and `ovf_clr_i` behave as described above.
- Undefined: `ovf_o` is tied to 0 and `ovf_clr_i` is ignored.
  - The counter still saturates at max.
  - Events arriving at max with no launch are dropped silently.

## Test plan
- Single event, CNT_W=4:
  - Stimulus: pulse at edge 10; bench models the receiver by echoing `req_o` onto `ack_async_i` with 2-cycle delay.
  - Required: `req_o` high edges 11–15 inclusive, low afterwards; `busy_o` mirrors the handshake; `pend_cnt_o` returns to 0.
- Burst of 5 consecutive pulses while idle:
  - Required: `pend_cnt_o` reaches 4 after the launch of the first.
  - Required: exactly 5 `req_o` rising edges; `pend_cnt_o` ends at 0; `ovf_o` stays 0.
- Overflow, CNT_W=2, ack held low:
  - Stimulus: 5 pulses.
  - Required: 1 launched; count saturates at 3; `ovf_o` = 1 on the 5th pulse.
  - Stimulus: `ovf_clr_i` together with a 6th pulse.
  - Required: `ovf_o` stays 1. A later lone clear gives `ovf_o` = 0.
- Simultaneous events:
  - Stimulus: pulse in the launch cycle with counter 1.
  - Required: counter stays 1; the second handshake follows without loss.
- Reset mid-REQ with counter 2:
  - Stimulus: `rst_b` low for 1 edge.
  - Required: `req_o`, `busy_o`, `pend_cnt_o`, `ovf_o` all 0 after that edge; no launch until a new pulse arrives.
- Macro undefined, CNT_W=2:
  - Stimulus: repeat the overflow scenario.
  - Required: `ovf_o` is constantly 0; count saturates at 3.
